// File: rtl/elevator_request_encoder.sv
// Request front end for the elevator controller: latches cabin/hall buttons, picks the next
// target floor with a SCAN rule, holds its code for the floor FSM and clears the floor after dwell.
module elevator_request_encoder #(
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] btn,
    input  logic [1:0] piso,
    input  logic       puertas,
    output logic [3:0] memoria,
    output logic [9:0] lamp,
    output logic       dir
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2
    } state_t;

    // Request bits that belong to floor f (cabin button plus its hall buttons).
    function automatic logic [9:0] floor_mask(input logic [1:0] f);
        logic [9:0] m;
        case (f)
            2'd0:    m = 10'b0000010001;
            2'd1:    m = 10'b0001100010;
            2'd2:    m = 10'b0110000100;
            2'd3:    m = 10'b1000001000;
            default: m = 10'b0000000000;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lowest_code(input logic [9:0] pend);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            c = pend[i] ? 4'(i + 1) : c;
        end
        return c;
    endfunction

    logic [9:0]    sync1_r, sync2_r, prev_r;
    logic [9:0]    rise_s;
    logic [9:0]    lamp_r, lamp_n;
    logic [9:0]    clear_s, block_s;
    logic [3:0]    memoria_r, memoria_n;
    logic [3:0]    floor_pend_s;
    logic [1:0]    target_r, target_n;
    logic [1:0]    up_floor_s, dn_floor_s, sel_floor_s;
    logic          up_found_s, dn_found_s, sel_dir_s;
    logic          dir_r, dir_n;
    logic [CW-1:0] cnt_r, cnt_n;
    state_t        state_r, state_n;

    assign rise_s       = sync2_r & ~prev_r;
    assign floor_pend_s = {|(lamp_r & floor_mask(2'd3)), |(lamp_r & floor_mask(2'd2)),
                           |(lamp_r & floor_mask(2'd1)), |(lamp_r & floor_mask(2'd0))};

    // Two-flop synchronizer followed by a rising-edge history flop per button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 10'd0;
            sync2_r <= 10'd0;
            prev_r  <= 10'd0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // SCAN target choice: continue in the current sense, reverse only when nothing lies ahead.
    always_comb begin
        up_found_s = 1'b0;
        up_floor_s = 2'd0;
        dn_found_s = 1'b0;
        dn_floor_s = 2'd0;
        for (int f = 3; f >= 0; f--) begin
            up_found_s = (floor_pend_s[f] && (f >= int'(piso))) ? 1'b1 : up_found_s;
            up_floor_s = (floor_pend_s[f] && (f >= int'(piso))) ? 2'(f) : up_floor_s;
        end
        for (int f = 0; f <= 3; f++) begin
            dn_found_s = (floor_pend_s[f] && (f <= int'(piso))) ? 1'b1 : dn_found_s;
            dn_floor_s = (floor_pend_s[f] && (f <= int'(piso))) ? 2'(f) : dn_floor_s;
        end
        if (dir_r) begin
            if (up_found_s) begin
                sel_floor_s = up_floor_s;
                sel_dir_s   = 1'b1;
            end else begin
                sel_floor_s = dn_floor_s;
                sel_dir_s   = 1'b0;
            end
        end else begin
            if (dn_found_s) begin
                sel_floor_s = dn_floor_s;
                sel_dir_s   = 1'b0;
            end else begin
                sel_floor_s = up_floor_s;
                sel_dir_s   = 1'b1;
            end
        end
    end

    // Next-state logic; presses for the floor being dwelt on re-open the doors instead of latching.
    always_comb begin
        state_n   = state_r;
        memoria_n = memoria_r;
        target_n  = target_r;
        dir_n     = dir_r;
        cnt_n     = cnt_r;
        clear_s   = 10'd0;
        block_s   = 10'd0;
        case (state_r)
            IDLE: begin
                memoria_n = 4'd0;
                if (|lamp_r) begin
                    target_n  = sel_floor_s;
                    dir_n     = sel_dir_s;
                    memoria_n = lowest_code(lamp_r & floor_mask(sel_floor_s));
                    state_n   = SERVE;
                end else begin
                    state_n   = IDLE;
                end
            end
            SERVE: begin
                if ((piso == target_r) && puertas) begin
                    state_n = DWELL;
                    cnt_n   = CNT_LOAD;
                end else begin
                    state_n = SERVE;
                end
            end
            DWELL: begin
                block_s = floor_mask(target_r);
                if (|(rise_s & block_s)) begin
                    cnt_n = CNT_LOAD;
                end else if (cnt_r == {CW{1'b0}}) begin
                    clear_s   = floor_mask(target_r);
                    memoria_n = 4'd0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_r - CW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                memoria_n = 4'd0;
            end
        endcase
        lamp_n = (lamp_r & ~clear_s) | (rise_s & ~block_s);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            memoria_r <= 4'd0;
            lamp_r    <= 10'd0;
            dir_r     <= 1'b1;
            target_r  <= 2'd0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            state_r   <= state_n;
            memoria_r <= memoria_n;
            lamp_r    <= lamp_n;
            dir_r     <= dir_n;
            target_r  <= target_n;
            cnt_r     <= cnt_n;
        end
    end

    assign memoria = memoria_r;
    assign lamp    = lamp_r;
    assign dir     = dir_r;

endmodule

// File: tb/tb_elevator_request_encoder.sv
// Bench for elevator_request_encoder: emulates the floor state machine, predicts the service
// order with a floor-level SCAN model and checks presented codes and door dwell in a monitor.
module tb_elevator_request_encoder;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] btn = 10'd0;
    logic [1:0] piso = 2'd0;
    logic       puertas = 1'b0;
    logic [3:0] memoria;
    logic [9:0] lamp;
    logic       dir;

    elevator_request_encoder #(.DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst(rst), .btn(btn), .piso(piso), .puertas(puertas),
        .memoria(memoria), .lamp(lamp), .dir(dir)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sb_q[$];
    int exp_open = DW + 1;
    int floor_tab[10] = '{0, 1, 2, 3, 0, 1, 1, 2, 2, 3};
    bit [9:0] m_pend = 10'd0;
    bit m_dir = 1'b1;
    int m_piso = 0;
    int home = 0;
    int home_gen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit floor_has(input int f);
        bit h;
        h = 1'b0;
        for (int c = 1; c <= 10; c++) if (m_pend[c-1] && floor_tab[c-1] == f) h = 1'b1;
        return h;
    endfunction

    // Serve everything pending in SCAN order, queueing each presented code.
    task automatic model_run();
        while (m_pend != 10'd0) begin
            int t;
            int code;
            t = -1;
            code = -1;
            if (m_dir) begin
                for (int f = m_piso; f <= 3; f++) if (t < 0 && floor_has(f)) t = f;
                if (t < 0) begin
                    m_dir = 1'b0;
                    for (int f = m_piso; f >= 0; f--) if (t < 0 && floor_has(f)) t = f;
                end
            end else begin
                for (int f = m_piso; f >= 0; f--) if (t < 0 && floor_has(f)) t = f;
                if (t < 0) begin
                    m_dir = 1'b1;
                    for (int f = m_piso; f <= 3; f++) if (t < 0 && floor_has(f)) t = f;
                end
            end
            for (int c = 1; c <= 10; c++) if (code < 0 && m_pend[c-1] && floor_tab[c-1] == t) code = c;
            sb_q.push_back(code);
            for (int c = 1; c <= 10; c++) if (floor_tab[c-1] == t) m_pend[c-1] = 1'b0;
            m_piso = t;
        end
    endtask

    task automatic press(input logic [9:0] mask, input int hold);
        @(posedge clk);
        #1 btn = mask;
        m_pend = m_pend | mask;
        model_run();
        repeat (hold) @(posedge clk);
        #1 btn = 10'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_piso(input int p);
        home = p;
        home_gen++;
        m_piso = p;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(memoria == 4'd0 && lamp == 10'd0 && sb_q.size() == 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle_reached"}, (k < 3000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_open(input int code, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(int'(memoria) == code && puertas) && k < 500);
        chk({name, "_doors_open"}, (k < 500) ? 1 : 0, 1);
    endtask

    // Floor state machine stand-in: one floor per 4 cycles, doors open on arrival.
    initial begin
        int mv;
        int seen_gen;
        mv = 0;
        seen_gen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (memoria == 4'd0) begin
                puertas = 1'b0;
                mv = 0;
                if (home_gen != seen_gen) begin
                    piso = 2'(home);
                    seen_gen = home_gen;
                end
            end else if (memoria > 4'd10) begin
                puertas = 1'b0;
            end else if (int'(piso) != floor_tab[int'(memoria) - 1]) begin
                puertas = 1'b0;
                mv++;
                if (mv >= 4) begin
                    mv = 0;
                    piso = (int'(piso) < floor_tab[int'(memoria) - 1]) ? piso + 2'd1 : piso - 2'd1;
                end
            end else begin
                puertas = 1'b1;
            end
        end
    end

    // Monitor: pops the expected code on every new request and measures the door-open span.
    initial begin
        logic [3:0] prev;
        int open_cnt;
        prev = 4'd0;
        open_cnt = 0;
        forever begin
            @(negedge clk);
            if (memoria != 4'd0 && prev == 4'd0) begin
                if (sb_q.size() == 0) chk("unexpected_request", int'(memoria), 0);
                else chk("request_code", int'(memoria), sb_q.pop_front());
                open_cnt = 0;
            end else if (memoria != 4'd0) begin
                chk("request_held", int'(memoria), int'(prev));
            end
            if (memoria != 4'd0 && puertas) open_cnt++;
            if (memoria == 4'd0 && prev != 4'd0 && exp_open > 0)
                chk("door_open_cycles", open_cnt, exp_open);
            prev = memoria;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_memoria", int'(memoria), 0);
        chk("reset_lamp", int'(lamp), 0);
        chk("reset_dir", int'(dir), 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Floor-3 cabin press from floor 1: lamp at E2, code at E3.
        @(posedge clk);
        #1 btn = 10'h004;
        m_pend = m_pend | 10'h004;
        model_run();
        @(posedge clk);
        #1 btn = 10'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lamp_at_e2", int'(lamp), 4);
        chk("memoria_before_e3", int'(memoria), 0);
        @(negedge clk);
        chk("memoria_at_e3", int'(memoria), 3);
        wait_idle("first");
        chk("first_lamp_clear", int'(lamp), 0);

        // Codes 1 and 9 from floor 2 heading up: 9 first, then reverse to 1.
        set_piso(1);
        press(10'h101, 2);
        wait_idle("scan");
        chk("scan_dir", int'(dir), int'(m_dir));

        // Codes 3 and 8 cleared together by one stop.
        set_piso(1);
        press(10'h084, 1);
        wait_open(3, "shared");
        chk("shared_both_pending", int'(lamp), 'h084);
        wait_idle("shared");
        chk("shared_lamp_clear", int'(lamp), 0);

        // Door re-open: floor-4 hall press during dwell cycle 5.
        set_piso(3);
        exp_open = 1 + 5 + DW;
        @(posedge clk);
        #1 btn = 10'h008;
        m_pend = m_pend | 10'h008;
        model_run();
        @(posedge clk);
        #1 btn = 10'd0;
        wait_open(4, "reopen");
        repeat (3) @(posedge clk);
        #1 btn = 10'h200;
        @(posedge clk);
        #1 btn = 10'd0;
        repeat (3) @(negedge clk);
        chk("reopen_lamp9_blocked", int'(lamp[9]), 0);
        chk("reopen_lamp3_pending", int'(lamp[3]), 1);
        wait_idle("reopen");
        exp_open = DW + 1;
        chk("reopen_lamp_clear", int'(lamp), 0);

        // Press during SERVE and hold it for 100 cycles.
        set_piso(0);
        press(10'h008, 1);
        @(posedge clk);
        #1 btn = 10'h001;
        m_pend = m_pend | 10'h001;
        model_run();
        repeat (4) @(negedge clk);
        chk("serve_lamp0_set", int'(lamp[0]), 1);
        chk("serve_memoria_kept", int'(memoria), 4);
        repeat (100) @(posedge clk);
        #1 btn = 10'd0;
        wait_idle("hold");
        chk("hold_single_set", int'(lamp), 0);

        // Asynchronous reset in the middle of a dwell.
        press(10'h202, 2);
        wait_open(2, "rst");
        repeat (3) @(negedge clk);
        exp_open = 0;
        #1 rst = 1'b0;
        #1;
        chk("rst_async_memoria", int'(memoria), 0);
        chk("rst_async_lamp", int'(lamp), 0);
        chk("rst_async_dir", int'(dir), 1);
        sb_q.delete();
        m_pend = 10'd0;
        m_dir = 1'b1;
        m_piso = int'(piso);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_open = DW + 1;
        chk("rst_requests_lost", int'(lamp), 0);
        chk("rst_no_request", int'(memoria), 0);

        // Randomized batches from random starting floors.
        for (int r = 0; r < 25; r++) begin
            set_piso(int'($urandom_range(0, 3)));
            press(10'($urandom_range(1, 1023)), int'($urandom_range(1, 3)));
            wait_idle("rand");
            chk("rand_lamp", int'(lamp), 0);
            chk("rand_dir", int'(dir), int'(m_dir));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
